mem_bus_bridge: RTL

Data-side bus bridge directly downstream of the MEM stage. Converts the MEM stage's single-cycle memory request (ce/we/addr/sel/data) into a valid/grant request plus in-order response bus transaction, and returns read data to MEM. Raises a stall request to the pipeline control unit until the access completes. Handles flushes that arrive mid-transaction.

---
 rtl/mem_bus_bridge_pkg.sv | 21 ++
 rtl/mem_bus_bridge.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_bridge_pkg.sv
// mem_bus_bridge_pkg: shared bus widths, FSM state encodings and address helper
// for the MEM-stage data bus bridge.
package mem_bus_bridge_pkg;

    localparam int BUS_AW  = 32;
    localparam int BUS_DW  = 32;
    localparam int BUS_BEW = 4;

    // Bridge FSM encodings (3-bit, kept as plain constants for legacy tools)
    localparam logic [2:0] MBR_IDLE  = 3'd0;
    localparam logic [2:0] MBR_REQ   = 3'd1;
    localparam logic [2:0] MBR_WAIT  = 3'd2;
    localparam logic [2:0] MBR_DONE  = 3'd3;
    localparam logic [2:0] MBR_DRAIN = 3'd4;

    // Word-align a byte address; lane selection travels separately on the byte enables
    function automatic logic [BUS_AW-1:0] word_addr(input logic [BUS_AW-1:0] byte_addr);
        return {byte_addr[BUS_AW-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/mem_bus_bridge.sv
// mem_bus_bridge: converts the MEM stage's single-cycle request into a
// valid/grant request plus in-order response transaction, stalls the pipeline
// until the access completes and absorbs responses of flushed instructions.
// Optional features:
//   MEM_BRIDGE_POSTED_WR_EN - stores complete at grant; the ack is tracked by posted_pend.
//   MEM_BRIDGE_TIMEOUT_EN   - response watchdog with sticky bus_err_o.
module mem_bus_bridge
    import mem_bus_bridge_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                mem_ce_i,
    input  logic                mem_we_i,
    input  logic [BUS_AW-1:0]   mem_addr_i,
    input  logic [BUS_BEW-1:0]  mem_sel_i,
    input  logic [BUS_DW-1:0]   mem_wdata_i,
    output logic [BUS_DW-1:0]   mem_rdata_o,
    input  logic                wb_stall_i,
    input  logic                flush_i,
    output logic                stallreq_o,
    output logic                bus_req_o,
    input  logic                bus_gnt_i,
    output logic                bus_we_o,
    output logic [BUS_AW-1:0]   bus_addr_o,
    output logic [BUS_BEW-1:0]  bus_be_o,
    output logic [BUS_DW-1:0]   bus_wdata_o,
    input  logic                bus_rvalid_i,
    input  logic [BUS_DW-1:0]   bus_rdata_i,
    output logic                bus_err_o
);

`ifdef MEM_BRIDGE_POSTED_WR_EN
    localparam logic POSTED_EN = 1'b1;
`else
    localparam logic POSTED_EN = 1'b0;
`endif

    logic [2:0]        state_q, state_d;
    logic [BUS_DW-1:0] data_q, data_d;
    logic              posted_pend_q, posted_pend_d;
    logic              bus_req_s;
    logic              stallreq_s;
    logic [BUS_DW-1:0] rdata_s;
    logic              posted_store_s;
    logic              tmo_hit_s;

    // A store that may retire at grant instead of waiting for its ack
    assign posted_store_s = POSTED_EN & mem_we_i;

`ifdef MEM_BRIDGE_TIMEOUT_EN
    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);

    logic [31:0] tmo_cnt_q, tmo_cnt_d;
    logic        bus_err_q, bus_err_d;
    logic        busy_s;

    assign busy_s    = (state_q == MBR_WAIT) | (state_q == MBR_DRAIN);
    assign tmo_hit_s = busy_s & ~bus_rvalid_i & (tmo_cnt_q == TMO_LAST);

    // Watchdog: count response-wait cycles, flag a sticky error on expiry
    always_comb begin
        bus_err_d = bus_err_q | tmo_hit_s;
        if (busy_s & ~bus_rvalid_i & ~tmo_hit_s) begin
            tmo_cnt_d = tmo_cnt_q + 32'd1;
        end else begin
            tmo_cnt_d = 32'd0;
        end
    end

    // Watchdog state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt_q <= 32'd0;
            bus_err_q <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            bus_err_q <= bus_err_d;
        end
    end

    assign bus_err_o = bus_err_q;
`else
    assign tmo_hit_s = 1'b0;
    assign bus_err_o = 1'b0;
`endif

    // Bridge FSM: next state, request/stall generation and read-data return
    always_comb begin
        state_d       = state_q;
        data_d        = data_q;
        posted_pend_d = posted_pend_q;
        bus_req_s     = 1'b0;
        stallreq_s    = 1'b0;
        rdata_s       = data_q;

        // A posted store's ack may arrive in any state
        if (posted_pend_q & bus_rvalid_i) begin
            posted_pend_d = 1'b0;
        end else begin
            posted_pend_d = posted_pend_q;
        end

        case (state_q)
            MBR_IDLE: begin
                bus_req_s = mem_ce_i & ~flush_i & ~posted_pend_q;
                if (bus_req_s & bus_gnt_i & posted_store_s) begin
                    posted_pend_d = 1'b1;
                    stallreq_s    = 1'b0;
                end else if (bus_req_s & bus_gnt_i) begin
                    state_d    = MBR_WAIT;
                    stallreq_s = 1'b1;
                end else if (bus_req_s) begin
                    state_d    = MBR_REQ;
                    stallreq_s = 1'b1;
                end else begin
                    stallreq_s = mem_ce_i & ~flush_i;
                end
            end
            MBR_REQ: begin
                bus_req_s = 1'b1;
                if (bus_gnt_i & posted_store_s) begin
                    posted_pend_d = 1'b1;
                    state_d       = MBR_IDLE;
                    stallreq_s    = 1'b0;
                end else if (bus_gnt_i & flush_i) begin
                    // Accepted but flushed: the response belongs to nobody
                    state_d    = MBR_DRAIN;
                    stallreq_s = 1'b1;
                end else if (bus_gnt_i) begin
                    state_d    = MBR_WAIT;
                    stallreq_s = 1'b1;
                end else if (flush_i) begin
                    state_d    = MBR_IDLE;
                    stallreq_s = 1'b1;
                end else begin
                    stallreq_s = 1'b1;
                end
            end
            MBR_WAIT: begin
                if (bus_rvalid_i | tmo_hit_s) begin
                    rdata_s    = bus_rvalid_i ? bus_rdata_i : {BUS_DW{1'b0}};
                    stallreq_s = 1'b0;
                    if (wb_stall_i & ~flush_i) begin
                        // MEM/WB frozen: hold the word so MEM sees it until it advances
                        state_d = MBR_DONE;
                        data_d  = rdata_s;
                    end else begin
                        state_d = MBR_IDLE;
                    end
                end else if (flush_i) begin
                    state_d    = MBR_DRAIN;
                    stallreq_s = 1'b1;
                end else begin
                    stallreq_s = 1'b1;
                end
            end
            MBR_DONE: begin
                if (~wb_stall_i | flush_i) begin
                    state_d = MBR_IDLE;
                end else begin
                    state_d = MBR_DONE;
                end
            end
            MBR_DRAIN: begin
                stallreq_s = mem_ce_i;
                if (bus_rvalid_i | tmo_hit_s) begin
                    state_d = MBR_IDLE;
                end else begin
                    state_d = MBR_DRAIN;
                end
            end
            default: begin
                state_d = MBR_IDLE;
            end
        endcase
    end

    // Bridge state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= MBR_IDLE;
            data_q        <= {BUS_DW{1'b0}};
            posted_pend_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            data_q        <= data_d;
            posted_pend_q <= posted_pend_d;
        end
    end

    // MEM is frozen while stalled, so pass-through bus fields stay stable
    assign bus_req_o   = bus_req_s;
    assign bus_we_o    = mem_we_i;
    assign bus_addr_o  = word_addr(mem_addr_i);
    assign bus_be_o    = mem_sel_i;
    assign bus_wdata_o = mem_wdata_i;
    assign stallreq_o  = stallreq_s;
    assign mem_rdata_o = rdata_s;

endmodule
